// File: rtl/rr_sel_arbiter4.sv
// Round-robin 4-way arbiter driving the select of a 4:1 datapath mux.
// Bounded burst per grant; registered sel/gnt/out_valid with valid/ready.
module rr_sel_arbiter4 #(
  parameter int MAX_BURST = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       out_valid
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MAXB = BW'(MAX_BURST);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [BW-1:0] burst_cnt;
  logic [2:0]    pk_idle;
  logic [2:0]    pk_rot;
  logic          hold;

  // {found, index}: first requester at or after p, wrapping mod 4
  function automatic logic [2:0] pick(
    input logic [3:0] r,
    input logic [1:0] p
  );
    logic [1:0] idx;
    pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) pick = {1'b1, idx};
    end
  endfunction

  assign pk_idle = pick(req, ptr);
  assign pk_rot  = pick(req, sel + 2'd1);
  assign hold    = req[sel] && (burst_cnt < MAXB);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel       <= 2'b00;
      gnt       <= 4'b0000;
      out_valid <= 1'b0;
      ptr       <= 2'b00;
      burst_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pk_idle[2]) begin
            state     <= GRANT;
            sel       <= pk_idle[1:0];
            gnt       <= 4'b0001 << pk_idle[1:0];
            out_valid <= 1'b1;
            burst_cnt <= BW'(1);
          end
        end
        GRANT: begin
          if (out_ready) begin
            if (hold) begin
              burst_cnt <= burst_cnt + BW'(1);
            end else begin
              ptr <= sel + 2'd1;
              if (pk_rot[2]) begin
                sel       <= pk_rot[1:0];
                gnt       <= 4'b0001 << pk_rot[1:0];
                burst_cnt <= BW'(1);
              end else begin
                state     <= IDLE;
                gnt       <= 4'b0000;
                out_valid <= 1'b0;
                burst_cnt <= '0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_sel_arbiter4.sv
// Bench for rr_sel_arbiter4: vector table, corner sequences, random vs model.
// Instance u0 uses MAX_BURST=2, u1 uses MAX_BURST=1.
module tb_rr_sel_arbiter4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       out_ready;
  logic [1:0] sel0, sel1;
  logic [3:0] gnt0, gnt1;
  logic       ov0, ov1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_sel_arbiter4 #(.MAX_BURST(2)) u0 (
    .clk(clk), .reset(reset), .req(req), .out_ready(out_ready),
    .sel(sel0), .gnt(gnt0), .out_valid(ov0)
  );

  rr_sel_arbiter4 #(.MAX_BURST(1)) u1 (
    .clk(clk), .reset(reset), .req(req), .out_ready(out_ready),
    .sel(sel1), .gnt(gnt1), .out_valid(ov1)
  );

  // Model: owner is the granted index, -1 when nobody holds the mux
  int m_own[2];
  int m_sel[2];
  int m_ptr[2];
  int m_cnt[2];
  int mb[2] = '{2, 1};

  function automatic int first_req(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++)
      if (r[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  task automatic model_step(input int k, input logic rst,
                            input logic [3:0] r, input logic rdy);
    int w;
    if (rst) begin
      m_own[k] = -1; m_sel[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0;
    end else if (m_own[k] < 0) begin
      w = first_req(r, m_ptr[k]);
      if (w >= 0) begin
        m_own[k] = w; m_sel[k] = w; m_cnt[k] = 1;
      end
    end else if (rdy) begin
      if (r[m_own[k]] && m_cnt[k] < mb[k]) begin
        m_cnt[k]++;
      end else begin
        m_ptr[k] = (m_own[k] + 1) % 4;
        w = first_req(r, m_ptr[k]);
        if (w >= 0) begin
          m_own[k] = w; m_sel[k] = w; m_cnt[k] = 1;
        end else begin
          m_own[k] = -1; m_cnt[k] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("m0_sel", int'(sel0), m_sel[0]);
    chk("m0_gnt", int'(gnt0), m_own[0] < 0 ? 0 : (1 << m_own[0]));
    chk("m0_valid", int'(ov0), m_own[0] < 0 ? 0 : 1);
    chk("m1_sel", int'(sel1), m_sel[1]);
    chk("m1_gnt", int'(gnt1), m_own[1] < 0 ? 0 : (1 << m_own[1]));
    chk("m1_valid", int'(ov1), m_own[1] < 0 ? 0 : 1);
  endtask

  // One clock: drive inputs, advance model at the edge, sample 1ns later
  task automatic cyc(input logic rst, input logic [3:0] r, input logic rdy);
    reset = rst; req = r; out_ready = rdy;
    @(posedge clk);
    model_step(0, rst, r, rdy);
    model_step(1, rst, r, rdy);
    #1;
    chk_model();
  endtask

  task automatic exp0(input string nm, input logic [1:0] s,
                      input logic [3:0] g, input logic v);
    chk({nm, "_sel"}, int'(sel0), int'(s));
    chk({nm, "_gnt"}, int'(gnt0), int'(g));
    chk({nm, "_valid"}, int'(ov0), int'(v));
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       ov;
  } vec_t;

  vec_t tbl[8];

  initial begin
    reset = 1'b1; req = 4'b0; out_ready = 1'b0;
    for (int k = 0; k < 2; k++) model_step(k, 1'b1, 4'b0, 1'b0);

    tbl[0] = '{1'b1, 4'b1111, 1'b1, 2'b00, 4'b0000, 1'b0};
    tbl[1] = '{1'b1, 4'b1111, 1'b1, 2'b00, 4'b0000, 1'b0};
    tbl[2] = '{1'b0, 4'b1010, 1'b1, 2'b01, 4'b0010, 1'b1};
    tbl[3] = '{1'b0, 4'b1010, 1'b1, 2'b01, 4'b0010, 1'b1};
    tbl[4] = '{1'b0, 4'b1010, 1'b1, 2'b11, 4'b1000, 1'b1};
    tbl[5] = '{1'b0, 4'b1010, 1'b1, 2'b11, 4'b1000, 1'b1};
    tbl[6] = '{1'b0, 4'b1010, 1'b1, 2'b01, 4'b0010, 1'b1};
    tbl[7] = '{1'b0, 4'b1010, 1'b1, 2'b01, 4'b0010, 1'b1};
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].rst, tbl[i].req, tbl[i].rdy);
      exp0($sformatf("tbl%0d", i), tbl[i].sel, tbl[i].gnt, tbl[i].ov);
    end

    // Stall on port 2; dropping req during the stall must not retract
    cyc(1'b1, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0100, 1'b0);
    exp0("stall_grant", 2'b10, 4'b0100, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 4'b0000, 1'b0);
      exp0("stall_hold", 2'b10, 4'b0100, 1'b1);
    end
    cyc(1'b0, 4'b0000, 1'b1);
    exp0("stall_done", 2'b10, 4'b0000, 1'b0);

    // Port 2 drops req before its final transfer; sel must stay 10
    cyc(1'b1, 4'b0000, 1'b1);
    cyc(1'b0, 4'b0100, 1'b1);
    exp0("drop_grant", 2'b10, 4'b0100, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1);
    exp0("drop_idle", 2'b10, 4'b0000, 1'b0);
    cyc(1'b0, 4'b0000, 1'b1);
    exp0("drop_idle2", 2'b10, 4'b0000, 1'b0);

    // MAX_BURST=1 single requester re-grants itself without a gap
    cyc(1'b1, 4'b0001, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 4'b0001, 1'b1);
      chk("mb1_sel", int'(sel1), 0);
      chk("mb1_valid", int'(ov1), 1);
      chk("mb1_gnt", int'(gnt1), 1);
    end

    // Reset mid-burst on port 3 restarts the pick from ptr=0
    cyc(1'b1, 4'b0000, 1'b1);
    cyc(1'b0, 4'b1000, 1'b1);
    exp0("rst_mid_g", 2'b11, 4'b1000, 1'b1);
    cyc(1'b1, 4'b1001, 1'b1);
    exp0("rst_mid_idle", 2'b00, 4'b0000, 1'b0);
    cyc(1'b0, 4'b1001, 1'b1);
    exp0("rst_mid_pick", 2'b00, 4'b0001, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 49) == 0),
          4'($urandom_range(0, 15)),
          ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
